// File: rtl/fwd_pkg.sv
// Shared types and constants for the EX-stage forwarding and hazard tracker.
package fwd_pkg;

    localparam int unsigned REG_ADDR_W_DEF = 5;
    // Tag rd storage width; users may set REG_ADDR_W up to this value.
    localparam int unsigned TAG_RD_W = 8;

    localparam logic [1:0] FWD_NONE  = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef struct packed {
        logic                valid;
        logic [TAG_RD_W-1:0] rd;
        logic                wr_en;
        logic                is_load;
    } tag_t;

endpackage

// File: rtl/fwd_match.sv
// One source operand versus the MEM and WB destination tags; nearest stage wins.
module fwd_match
    import fwd_pkg::*;
(
    input  logic [TAG_RD_W-1:0] rs,
    input  logic                mem_live,
    input  logic [TAG_RD_W-1:0] mem_rd,
    input  logic                wb_live,
    input  logic [TAG_RD_W-1:0] wb_rd,
    output logic [1:0]          sel_c
);

    always_comb begin
        sel_c = FWD_NONE;
        if (mem_live && (mem_rd == rs)) begin
            sel_c = FWD_EXMEM;
        end else if (wb_live && (wb_rd == rs)) begin
            sel_c = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX/MEM/WB tag tracker: operand forwarding selects, load-use stall and mul/div hold.
// Optional WB->ID bypass output enabled by defining FWD_WB_BYPASS_EN.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned MULDIV_LAT = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          id_valid_i,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0]         id_rd_i,
    input  logic                          id_wr_en_i,
    input  logic                          id_is_load_i,
    input  logic                          id_is_muldiv_i,
    input  logic                          ext_hold_i,
    input  logic                          flush_i,
    output logic [NUM_SRC*2-1:0]          fwd_sel_o,
    output logic                          stall_id_o,
    output logic                          bubble_ex_o,
`ifdef FWD_WB_BYPASS_EN
    output logic [NUM_SRC-1:0]            id_bypass_o,
`endif
    output logic                          busy_o
);

    localparam int unsigned CNT_W = $clog2(MULDIV_LAT);

    tag_t                          ex_q;
    tag_t                          mem_q;
    tag_t                          wb_q;
    tag_t                          cap;
    logic [NUM_SRC*REG_ADDR_W-1:0] ex_rs_q;
    logic [CNT_W-1:0]              cnt_q;

    logic adv;
    logic id_hit;
    logic load_use;
    logic mem_live;
    logic wb_live;

    // WB is_load is carried for entry uniformity but nothing downstream reads it.
    logic unused_wb_load;
    assign unused_wb_load = wb_q.is_load;

    always_comb begin
        id_hit = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (TAG_RD_W'(id_rs_i[k*REG_ADDR_W +: REG_ADDR_W]) == ex_q.rd) begin
                id_hit = 1'b1;
            end
        end

        busy_o   = (cnt_q != '0);
        adv      = !ext_hold_i && !busy_o;
        mem_live = mem_q.valid && mem_q.wr_en && (mem_q.rd != '0);
        wb_live  = wb_q.valid && wb_q.wr_en && (wb_q.rd != '0);
        load_use = ex_q.valid && ex_q.is_load && ex_q.wr_en && (ex_q.rd != '0)
                   && id_valid_i && id_hit;

        // A redirect kills ID this cycle, so it also masks the stall request.
        stall_id_o  = !flush_i && (load_use || busy_o);
        bubble_ex_o = stall_id_o && adv;

        cap         = '0;
        cap.valid   = id_valid_i && !stall_id_o && !flush_i;
        cap.rd      = TAG_RD_W'(id_rd_i);
        cap.wr_en   = id_wr_en_i;
        cap.is_load = id_is_load_i;
    end

    // Tag shift pipeline and mul/div occupancy counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            ex_rs_q <= '0;
            cnt_q   <= '0;
        end else begin
            if (adv) begin
                wb_q    <= mem_q;
                mem_q   <= ex_q;
                ex_q    <= cap;
                ex_rs_q <= id_rs_i;
            end
            if (flush_i) begin
                ex_q.valid <= 1'b0;
                cnt_q      <= '0;
            end else if (adv && cap.valid && id_is_muldiv_i) begin
                cnt_q <= CNT_W'(MULDIV_LAT - 1);
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        fwd_match u_match (
            .rs       (TAG_RD_W'(ex_rs_q[k*REG_ADDR_W +: REG_ADDR_W])),
            .mem_live (mem_live),
            .mem_rd   (mem_q.rd),
            .wb_live  (wb_live),
            .wb_rd    (wb_q.rd),
            .sel_c    (fwd_sel_o[k*2 +: 2])
        );
    end

`ifdef FWD_WB_BYPASS_EN
    // WB result overrides the register-file read for a same-cycle ID consumer.
    always_comb begin
        id_bypass_o = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            id_bypass_o[k] = wb_live
                && (TAG_RD_W'(id_rs_i[k*REG_ADDR_W +: REG_ADDR_W]) == wb_q.rd);
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed scenarios plus a randomized run against an instruction-level pipeline model.
module tb_fwd_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid_i;
    logic [9:0] id_rs_i;
    logic [4:0] id_rd_i;
    logic       id_wr_en_i;
    logic       id_is_load_i;
    logic       id_is_muldiv_i;
    logic       ext_hold_i;
    logic       flush_i;
    logic [3:0] fwd_sel_o;
    logic       stall_id_o;
    logic       bubble_ex_o;
    logic       busy_o;
`ifdef FWD_WB_BYPASS_EN
    logic [1:0] id_bypass_o;
`endif

    int checks = 0;
    int errors = 0;

    fwd_hazard_unit #(.REG_ADDR_W(5), .NUM_SRC(2), .MULDIV_LAT(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid_i     (id_valid_i),
        .id_rs_i        (id_rs_i),
        .id_rd_i        (id_rd_i),
        .id_wr_en_i     (id_wr_en_i),
        .id_is_load_i   (id_is_load_i),
        .id_is_muldiv_i (id_is_muldiv_i),
        .ext_hold_i     (ext_hold_i),
        .flush_i        (flush_i),
        .fwd_sel_o      (fwd_sel_o),
        .stall_id_o     (stall_id_o),
        .bubble_ex_o    (bubble_ex_o),
`ifdef FWD_WB_BYPASS_EN
        .id_bypass_o    (id_bypass_o),
`endif
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    // Instruction-level model: one record per pipeline slot.
    typedef struct {
        bit          v;
        int unsigned rd;
        bit          wr;
        bit          ld;
        int unsigned rs0;
        int unsigned rs1;
    } minst_t;

    minst_t m_ex, m_mem, m_wb;
    int     m_busy_left;

    task automatic drive(input bit v, input int unsigned rs1, input int unsigned rs2,
                         input int unsigned rd, input bit wr, input bit ld, input bit md);
        id_valid_i     = v;
        id_rs_i        = {5'(rs2), 5'(rs1)};
        id_rd_i        = 5'(rd);
        id_wr_en_i     = wr;
        id_is_load_i   = ld;
        id_is_muldiv_i = md;
    endtask

    task automatic idle();
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        ext_hold_i = 1'b0;
        flush_i    = 1'b0;
        repeat (8) tick();
    endtask

    function automatic logic [1:0] exp_sel(input int unsigned rs);
        if (m_mem.v && m_mem.wr && m_mem.rd != 0 && m_mem.rd == rs) return 2'b01;
        if (m_wb.v && m_wb.wr && m_wb.rd != 0 && m_wb.rd == rs) return 2'b10;
        return 2'b00;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        ext_hold_i = 1'b0;
        flush_i = 1'b0;
        idle();
        #12;
        checks++;
        if ({fwd_sel_o, stall_id_o, bubble_ex_o, busy_o} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want %b",
                     {fwd_sel_o, stall_id_o, bubble_ex_o, busy_o}, 7'b0);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1, 2, 5, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5, 6, 8, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (stall_id_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stall: got %b want 0", stall_id_o);
        end
        tick();
        idle();
        #1;
        checks++;
        if (fwd_sel_o !== 4'b0001) begin
            errors++;
            $display("FAIL b2b_fwd: got %b want 0001", fwd_sel_o);
        end
        drain();
    endtask

    task automatic test_distance2();
        drive(1'b1, 1, 2, 7, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1, 2, 9, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3, 7, 10, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        #1;
        checks++;
        if (fwd_sel_o !== 4'b1000) begin
            errors++;
            $display("FAIL dist2_wb: got %b want 1000", fwd_sel_o);
        end
        drain();
        drive(1'b1, 1, 2, 7, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1, 2, 7, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3, 7, 10, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        #1;
        checks++;
        if (fwd_sel_o !== 4'b0100) begin
            errors++;
            $display("FAIL dist2_nearest: got %b want 0100", fwd_sel_o);
        end
        drain();
    endtask

    task automatic test_load_use();
        drive(1'b1, 1, 2, 3, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 3, 4, 10, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if ({stall_id_o, bubble_ex_o} !== 2'b11) begin
            errors++;
            $display("FAIL lu_stall: got %b want 11", {stall_id_o, bubble_ex_o});
        end
        tick();
        #1;
        checks++;
        if ({stall_id_o, bubble_ex_o} !== 2'b00) begin
            errors++;
            $display("FAIL lu_release: got %b want 00", {stall_id_o, bubble_ex_o});
        end
        tick();
        idle();
        #1;
        checks++;
        if (fwd_sel_o !== 4'b0010) begin
            errors++;
            $display("FAIL lu_fwd: got %b want 0010", fwd_sel_o);
        end
        drain();
        // Destination x0 never stalls or forwards.
        drive(1'b1, 1, 2, 0, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 0, 4, 11, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (stall_id_o !== 1'b0) begin
            errors++;
            $display("FAIL x0_stall: got %b want 0", stall_id_o);
        end
        tick();
        idle();
        #1;
        checks++;
        if (fwd_sel_o !== 4'b0000) begin
            errors++;
            $display("FAIL x0_fwd: got %b want 0000", fwd_sel_o);
        end
        drain();
    endtask

    task automatic test_muldiv();
        drive(1'b1, 1, 2, 11, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b1, 11, 4, 12, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({busy_o, stall_id_o, bubble_ex_o} !== 3'b110) begin
                errors++;
                $display("FAIL md_busy%0d: got %b want 110", i,
                         {busy_o, stall_id_o, bubble_ex_o});
            end
            tick();
        end
        #1;
        checks++;
        if ({busy_o, stall_id_o} !== 2'b00) begin
            errors++;
            $display("FAIL md_done: got %b want 00", {busy_o, stall_id_o});
        end
        tick();
        idle();
        #1;
        checks++;
        if (fwd_sel_o !== 4'b0001) begin
            errors++;
            $display("FAIL md_fwd: got %b want 0001", fwd_sel_o);
        end
        drain();
    endtask

    task automatic test_hold();
        drive(1'b1, 1, 2, 5, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5, 6, 8, 1'b1, 1'b0, 1'b0);
        tick();
        ext_hold_i = 1'b1;
        drive(1'b1, 20, 21, 13, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({fwd_sel_o, bubble_ex_o} !== 5'b00010) begin
                errors++;
                $display("FAIL hold_fwd%0d: got %b want 00010", i, {fwd_sel_o, bubble_ex_o});
            end
            tick();
        end
        ext_hold_i = 1'b0;
        idle();
        tick();
        #1;
        checks++;
        if (fwd_sel_o !== 4'b0000) begin
            errors++;
            $display("FAIL hold_release: got %b want 0000", fwd_sel_o);
        end
        drain();
        // Load-use while held: stall without bubble until the first advancing edge.
        drive(1'b1, 1, 2, 3, 1'b1, 1'b1, 1'b0);
        tick();
        ext_hold_i = 1'b1;
        drive(1'b1, 3, 4, 14, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if ({stall_id_o, bubble_ex_o} !== 2'b10) begin
                errors++;
                $display("FAIL hold_lu%0d: got %b want 10", i, {stall_id_o, bubble_ex_o});
            end
            tick();
        end
        ext_hold_i = 1'b0;
        #1;
        checks++;
        if ({stall_id_o, bubble_ex_o} !== 2'b11) begin
            errors++;
            $display("FAIL hold_lu_adv: got %b want 11", {stall_id_o, bubble_ex_o});
        end
        tick();
        tick();
        idle();
        #1;
        checks++;
        if (fwd_sel_o !== 4'b0010) begin
            errors++;
            $display("FAIL hold_lu_fwd: got %b want 0010", fwd_sel_o);
        end
        drain();
    endtask

    task automatic test_flush();
        drive(1'b1, 1, 2, 11, 1'b1, 1'b0, 1'b1);
        tick();
        flush_i = 1'b1;
        drive(1'b1, 11, 4, 12, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if ({busy_o, stall_id_o} !== 2'b10) begin
            errors++;
            $display("FAIL flush_mask: got %b want 10", {busy_o, stall_id_o});
        end
        tick();
        flush_i = 1'b0;
        #1;
        checks++;
        if ({busy_o, stall_id_o} !== 2'b00) begin
            errors++;
            $display("FAIL flush_busy: got %b want 00", {busy_o, stall_id_o});
        end
        tick();
        idle();
        #1;
        checks++;
        if (fwd_sel_o !== 4'b0000) begin
            errors++;
            $display("FAIL flush_ex_inv: got %b want 0000", fwd_sel_o);
        end
        drain();
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1, 2, 3, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 3, 4, 10, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (stall_id_o !== 1'b1) begin
            errors++;
            $display("FAIL arst_pre: got %b want 1", stall_id_o);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({fwd_sel_o, stall_id_o, bubble_ex_o, busy_o} !== 7'b0) begin
            errors++;
            $display("FAIL arst_clear: got %b want %b",
                     {fwd_sel_o, stall_id_o, bubble_ex_o, busy_o}, 7'b0);
        end
        #1;
        rst_n = 1'b1;
        drain();
    endtask

    task automatic test_random();
        logic [3:0]  want_sel;
        bit          want_busy, want_stall, want_bubble, adv, lu, md;
        int unsigned rs0, rs1;
        minst_t      cap;

        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
        m_ex = '{default: 0};
        m_mem = '{default: 0};
        m_wb = '{default: 0};
        m_busy_left = 0;

        for (int c = 0; c < 600; c++) begin
            rs0 = $urandom_range(0, 7);
            rs1 = $urandom_range(0, 7);
            md  = ($urandom_range(0, 9) == 0);
            drive(($urandom_range(0, 3) != 0), rs0, rs1, $urandom_range(0, 7),
                  ($urandom_range(0, 4) != 0), ($urandom_range(0, 3) == 0), md);
            ext_hold_i = ($urandom_range(0, 6) == 0);
            flush_i    = ($urandom_range(0, 19) == 0);
            #1;

            want_sel    = {exp_sel(m_ex.rs1), exp_sel(m_ex.rs0)};
            want_busy   = (m_busy_left > 0);
            lu          = m_ex.v && m_ex.ld && m_ex.wr && m_ex.rd != 0 && id_valid_i
                          && (rs0 == m_ex.rd || rs1 == m_ex.rd);
            want_stall  = !flush_i && (lu || want_busy);
            adv         = !ext_hold_i && !want_busy;
            want_bubble = want_stall && adv;

            checks++;
            if (fwd_sel_o !== want_sel) begin
                errors++;
                $display("FAIL rnd_fwd c%0d: got %b want %b", c, fwd_sel_o, want_sel);
            end
            checks++;
            if (stall_id_o !== want_stall) begin
                errors++;
                $display("FAIL rnd_stall c%0d: got %b want %b", c, stall_id_o, want_stall);
            end
            checks++;
            if (bubble_ex_o !== want_bubble) begin
                errors++;
                $display("FAIL rnd_bubble c%0d: got %b want %b", c, bubble_ex_o, want_bubble);
            end
            checks++;
            if (busy_o !== want_busy) begin
                errors++;
                $display("FAIL rnd_busy c%0d: got %b want %b", c, busy_o, want_busy);
            end

            cap = '{v: (id_valid_i && !want_stall && !flush_i), rd: 32'(id_rd_i),
                    wr: id_wr_en_i, ld: id_is_load_i, rs0: rs0, rs1: rs1};
            if (adv) begin
                m_wb  = m_mem;
                m_mem = m_ex;
                m_ex  = cap;
            end
            if (flush_i) begin
                m_ex.v = 1'b0;
                m_busy_left = 0;
            end else if (adv && cap.v && md) begin
                m_busy_left = 3;
            end else if (m_busy_left > 0) begin
                m_busy_left--;
            end
            tick();
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_distance2();
        test_load_use();
        test_muldiv();
        test_hold();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the combinational EX-stage forwarding selector.
- Tracks destination tags for the EX, MEM and WB stages internally, with its own shift pipeline.
- Generates per-operand forwarding selects for NUM_SRC source operands, a load-use stall with bubble injection, and a multi-cycle mul/div hold counter.
- Sits beside the ID/EX pipeline registers and feeds the EX operand muxes and the pipeline stall/flush logic.

Parameters:
- REG_ADDR_W, 5, register-address width.
- NUM_SRC, 2, source operands per instruction (2 or 3).
- MULDIV_LAT, 4, EX occupancy in cycles of a mul/div op (≥2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid_i  in  1  ID holds a valid instruction.
- id_rs_i  in  NUM_SRC*REG_ADDR_W  ID source addresses; operand k is at bits [k*REG_ADDR_W +: REG_ADDR_W].
- id_rd_i  in  REG_ADDR_W  ID destination.
- id_wr_en_i  in  1  ID instruction writes rd.
- id_is_load_i  in  1  ID instruction is a load.
- id_is_muldiv_i  in  1  ID instruction is mul/div.
- ext_hold_i  in  1  external stall (e.g. memory wait); freezes the tracker.
- flush_i  in  1  kill the instructions in ID and EX (branch redirect).
- fwd_sel_o  out  NUM_SRC*2  per EX operand: 00 none, 01 from EX/MEM, 10 from MEM/WB, 11 unused.
- stall_id_o  out  1  hold PC and IF/ID.
- bubble_ex_o  out  1  insert a NOP into ID/EX this cycle.
- busy_o  out  1  mul/div occupying EX.

Behaviour:
- Tracker state: three tag entries, EX, MEM and WB.
  - Each entry holds {valid, rd, wr_en, is_load}.
  - The EX entry also holds rs[NUM_SRC].
  - Reset clears every valid bit and the busy counter.
- Reset values: fwd_sel_o=0, stall_id_o=0, bubble_ex_o=0, busy_o=0.
- Advance condition: adv = !ext_hold_i && !busy_o.
  - On an adv edge: WB<=MEM, MEM<=EX, EX<=ID capture.
  - The ID capture is invalid if stall_id_o, flush_i or !id_valid_i.
  - When adv=0, all entries hold.
- Forwarding is combinational from the registered EX/MEM/WB entries; latency 0 relative to the EX stage.
  - Operand k gets 01 if MEM.valid && MEM.wr_en && MEM.rd!=0 && MEM.rd==EX.rs[k].
  - Else it gets 10 under the same test on WB.
  - Else it gets 00.
  - The nearest stage wins.
  - Selects stay valid during ext_hold_i and busy, because the tags are frozen consistently.
- Load-use hazard: stall_id_o=1 when EX.valid && EX.is_load && EX.wr_en && EX.rd!=0 && id_valid_i && any id_rs==EX.rd.
  - bubble_ex_o = stall_id_o && adv.
  - The stall lasts exactly one advance. The load then sits in MEM and the consumer resolves via select 10 one cycle later.
- Mul/div:
  - On an adv edge capturing a valid muldiv instruction into EX, the counter loads MULDIV_LAT-1.
  - busy_o = (counter!=0). The counter decrements every cycle regardless of ext_hold_i.
  - stall_id_o is also asserted while busy_o=1.
  - A mul/div therefore occupies EX for MULDIV_LAT cycles.
- Flush:
  - flush_i on an edge invalidates the EX entry and zeroes the counter. This takes priority over adv and hold.
  - The MEM and WB entries still advance when adv=1.
  - flush_i masks the stall outputs in the same cycle.
- Simultaneous load-use and ext_hold_i: stall_id_o=1, bubble_ex_o=0. The bubble is inserted on the first advancing edge.
- Mid-operation reset: asynchronous clear of all entries and the counter; outputs return to reset values immediately.

Optional Feature:
- Macro FWD_WB_BYPASS_EN.
- Defined: adds output id_bypass_o [NUM_SRC-1:0].
  - Bit k is set when WB.valid && WB.wr_en && WB.rd!=0 && WB.rd==id_rs[k].
  - It selects the WB data over the register-file read in ID, for a write-before-read-unsafe register file.
- Undefined: the port is absent. The register file must be write-first.

Decomposition:
- Shared package fwd_pkg:
  - Select constants FWD_NONE=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10.
  - The tag-entry struct typedef {valid, rd, wr_en, is_load}.
  - The REG_ADDR_W default.
- One natural sub-module, fwd_match: compares one source address against MEM/WB tags and returns a 2-bit select. It is instantiated NUM_SRC times via generate.

Test Plan:
- Back-to-back ALU: ADD x5 then SUB uses x5 as rs1 -> in the consumer's EX cycle, fwd_sel_o[1:0]=01, no stall.
- Distance-2 dependence: producer x7, one independent instruction, consumer rs2=x7 -> fwd_sel_o[3:2]=10. With x7 also written by the intermediate instruction -> 01 (nearest wins).
- Load-use: LW x3 then ADD rs1=x3 -> stall_id_o=1 and bubble_ex_o=1 for one cycle, then fwd_sel_o[1:0]=10. Destination x0 -> never stalls or forwards.
- Mul/div with MULDIV_LAT=4: MUL enters EX -> busy_o=1 for 3 cycles, stall_id_o high, tags frozen. The dependent consumer then gets 01.
- ext_hold_i high for 5 cycles during an EX/MEM match -> fwd_sel_o holds 01 throughout, no bubble. Release -> normal advance.
- flush_i during mul/div busy -> busy_o=0 next cycle, EX entry invalid. rst_n pulse mid-stream -> all outputs 0 asynchronously.
